// File: rtl/audio_in_pkg.sv
// Shared reader state encoding and drop counter ceiling for the stereo audio FIFO reader.
package audio_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } reader_state_e;

  localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/audio_settle_timer.sv
// Down-counting guard timer: loaded on a pop, done_o pulses in the last of SETTLE_CYCLES cycles.
module audio_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(SETTLE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/audio_in_stereo_reader.sv
// Pairs words from two show-ahead audio FIFOs into stereo samples; optional mono mix via AUDIO_IN_MONO_MIX_EN.
// States: IDLE = wait for data / pop | SETTLE = guard while read-space lags | HOLD = sample presented.
import audio_in_pkg::*;

module audio_in_stereo_reader #(
  parameter int unsigned AUDIO_DATA_WIDTH = 16,
  parameter int unsigned SETTLE_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                left_audio_fifo_read_space,
  input  logic [7:0]                right_audio_fifo_read_space,
  input  logic [AUDIO_DATA_WIDTH:1] left_channel_data,
  input  logic [AUDIO_DATA_WIDTH:1] right_channel_data,
  output logic                      read_left_audio_data_en,
  output logic                      read_right_audio_data_en,
  input  logic                      sample_ready,
  output logic                      sample_valid,
  output logic [AUDIO_DATA_WIDTH:1] sample_left,
  output logic [AUDIO_DATA_WIDTH:1] sample_right,
`ifdef AUDIO_IN_MONO_MIX_EN
  output logic [AUDIO_DATA_WIDTH:1] sample_mono,
`endif
  output logic [7:0]                drop_count
);

  reader_state_e             state_q, state_d;
  logic                      paired_q, paired_d;
  logic                      armed_q;
  logic [AUDIO_DATA_WIDTH:1] left_q, right_q;
  logic [7:0]                drop_q, drop_d;
  logic                      pop_left, pop_right, capture, drop, settle_done;

  wire left_avail  = |left_audio_fifo_read_space;
  wire right_avail = |right_audio_fifo_read_space;
  wire left_full   = left_audio_fifo_read_space[7];
  wire right_full  = right_audio_fifo_read_space[7];

  audio_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .load_i (pop_left | pop_right),
    .done_o (settle_done)
  );

  always_comb begin
    state_d   = state_q;
    paired_d  = paired_q;
    pop_left  = 1'b0;
    pop_right = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // armed_q keeps the first pop off the first edge after reset release
        if (armed_q) begin
          if (left_avail && right_avail) begin
            pop_left  = 1'b1;
            pop_right = 1'b1;
            capture   = 1'b1;
            paired_d  = 1'b1;
            state_d   = ST_SETTLE;
          end else if (left_full && !right_avail) begin
            pop_left = 1'b1;
            drop     = 1'b1;
            paired_d = 1'b0;
            state_d  = ST_SETTLE;
          end else if (right_full && !left_avail) begin
            pop_right = 1'b1;
            drop      = 1'b1;
            paired_d  = 1'b0;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: if (settle_done) state_d = paired_q ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (sample_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != DROP_COUNT_MAX)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      paired_q <= 1'b0;
      armed_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      paired_q <= paired_d;
      armed_q  <= 1'b1;
      drop_q   <= drop_d;
      if (capture) begin
        left_q  <= left_channel_data;
        right_q <= right_channel_data;
      end
    end
  end

`ifdef AUDIO_IN_MONO_MIX_EN
  // floor((l+r)/2) == (l>>>1) + (r>>>1) + (l0 & r0): same as the widened sum shifted, without overflow
  logic [AUDIO_DATA_WIDTH:1] mono_q, mono_d;
  assign mono_d = {left_channel_data[AUDIO_DATA_WIDTH],  left_channel_data[AUDIO_DATA_WIDTH:2]}
                + {right_channel_data[AUDIO_DATA_WIDTH], right_channel_data[AUDIO_DATA_WIDTH:2]}
                + {{(AUDIO_DATA_WIDTH-1){1'b0}}, left_channel_data[1] & right_channel_data[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mono_q <= '0;
    else if (capture) mono_q <= mono_d;
  end

  assign sample_mono = mono_q;
`endif

  assign read_left_audio_data_en  = pop_left;
  assign read_right_audio_data_en = pop_right;
  assign sample_valid             = (state_q == ST_HOLD);
  assign sample_left              = left_q;
  assign sample_right             = right_q;
  assign drop_count               = drop_q;

endmodule

// File: doc/audio_in_stereo_reader.md
AUDIO_IN_STEREO_READER -- requirements
Module: audio_in_stereo_reader

Interface
REQ-001 SHALL have parameter AUDIO_DATA_WIDTH, default 16, sample width per channel.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, guard cycles after a pop while the read-space inputs lag.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports left_audio_fifo_read_space / right_audio_fifo_read_space  input  8  registered FIFO occupancy; bit 7 = full, bits 6:0 = words used.
REQ-006 SHALL have ports left_channel_data / right_channel_data  input  [AUDIO_DATA_WIDTH:1]  show-ahead FIFO head word.
REQ-007 SHALL have ports read_left_audio_data_en / read_right_audio_data_en  output  1  one-cycle pop strobes.
REQ-008 SHALL have port sample_ready  input  1  downstream accepts the sample.
REQ-009 SHALL have port sample_valid  output  1  stereo sample held on the outputs.
REQ-010 SHALL have ports sample_left / sample_right  output  [AUDIO_DATA_WIDTH:1]  captured samples.
REQ-011 SHALL have port drop_count  output  8  saturating count of discarded unpaired words.

Function
REQ-012 Channel available SHALL mean read_space != 0 (full reads as 8'h80).
REQ-013 FSM states SHALL be IDLE, SETTLE, HOLD.
REQ-014 IDLE, both available: same cycle capture both data inputs into sample_left/right, pulse both pop strobes, go to SETTLE.
REQ-015 IDLE, one FIFO full (bit 7) and the other empty: pop only the full FIFO, do not capture, increment drop_count (stop at 8'hFF), go to SETTLE.
REQ-016 IDLE, any other combination: no pops, stay in IDLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, no pops; then go to HOLD if a pair was captured, else IDLE.
REQ-018 HOLD: sample_valid=1, outputs stable; on sample_ready=1 go to IDLE next cycle; sample_valid deasserts that same edge.
REQ-019 Pop strobes SHALL never be high for more than one consecutive cycle and never outside IDLE.
REQ-020 Latency: pair available in IDLE -> sample_valid high SETTLE_CYCLES+1 cycles later.
REQ-021 Sustained throughput SHALL be at most one pair per SETTLE_CYCLES+2 cycles with sample_ready tied high.

Reset
REQ-022 On reset assertion (asynchronous, any state, mid-HOLD included): state=IDLE, sample_valid=0, pop strobes=0, sample_left/right=0, drop_count=0.
REQ-023 The first pop SHALL be no earlier than the second clk edge after reset deasserts.

Configuration
REQ-024 Macro AUDIO_IN_MONO_MIX_EN defined: add output sample_mono [AUDIO_DATA_WIDTH:1] = signed (left+right) computed at AUDIO_DATA_WIDTH+1 bits, arithmetic right shift 1, registered at capture, valid with sample_valid, reset to 0.
REQ-025 Macro undefined: port sample_mono and adder SHALL not exist; all other behaviour identical.

Structure
REQ-026 State enum and the drop_count saturation value SHALL live in package audio_in_pkg.
REQ-027 The settle counter SHALL be sub-module audio_settle_timer (load on pop, done pulse after SETTLE_CYCLES); everything else stays flat.

Verification
REQ-028 Both read_space=8'h01, L=16'h1234, R=16'hABCD, ready=1 -> single pop on both; sample_valid 3 cycles later; outputs 1234/ABCD.
REQ-029 Pair captured, ready=0 for 10 cycles -> valid held 10+ cycles, outputs stable, no further pops until handshake.
REQ-030 left=8'h80, right=8'h00 -> only left pops, drop_count=1, no valid; repeated 300 times -> drop_count=8'hFF.
REQ-031 Reset asserted mid-HOLD -> all outputs zero immediately, without waiting for a clk edge.
REQ-032 AUDIO_IN_MONO_MIX_EN, L=16'h7FFF, R=16'h7FFF -> mono 16'h7FFF; L=16'h8000, R=16'h0001 -> 16'hC000.
REQ-033 Both FIFOs at 8'h05, ready=1 -> exactly 5 pairs, pops spaced 4 cycles apart, then idle.
